// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR round-robin scheduler slice.
package lfsr_pkg;

    localparam int unsigned MAX_W = 32;

    localparam logic [3:0] DEFAULT_TAPS_4 = 4'b0011;
    localparam logic [3:0] DEFAULT_SEED_4 = 4'b0001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        ADVANCE = 2'd2
    } state_t;

    // One Galois step on the low w bits of s; upper bits are cleared.
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] s,
                                                  input logic [MAX_W-1:0] taps,
                                                  input int unsigned      w);
        logic [MAX_W-1:0] shifted;
        logic [MAX_W-1:0] mask;
        mask    = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        shifted = {s[MAX_W-2:0], 1'b0};
        if (s[5'(w - 1)]) begin
            shifted = shifted ^ taps;
        end
        return shifted & mask;
    endfunction

endpackage

// File: rtl/lfsr_rr_scheduler_if.sv
// Request/grant/random-word bundle between consumers and the scheduler.
interface lfsr_rr_scheduler_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 4
);
    logic         enable;
    logic         seed_load;
    logic [W-1:0] seed;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         rnd_valid;
    logic [W-1:0] rnd_data;
    logic         lockup;

    modport master (
        output enable, seed_load, seed, req,
        input  grant, rnd_valid, rnd_data, lockup
    );

    modport slave (
        input  enable, seed_load, seed, req,
        output grant, rnd_valid, rnd_data, lockup
    );
endinterface

// File: rtl/lfsr_core.sv
// W-bit Galois LFSR register with load (priority) and step.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned W          = 4,
    parameter logic [W-1:0] TAPS       = W'(DEFAULT_TAPS_4),
    parameter logic [W-1:0] RESET_SEED = W'(DEFAULT_SEED_4)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= RESET_SEED;
        end else if (load) begin
            value <= load_value;
        end else if (step) begin
            value <= W'(lfsr_next(MAX_W'(value), MAX_W'(TAPS), W));
        end
    end

endmodule

// File: rtl/lfsr_rr_scheduler.sv
// Round-robin sharing of one LFSR between N requesters; one word per grant,
// STEPS LFSR advances between grants, seed load and zero-lockup recovery.
module lfsr_rr_scheduler
    import lfsr_pkg::*;
#(
    parameter int unsigned  N          = 4,
    parameter int unsigned  W          = 4,
    parameter logic [W-1:0] TAPS       = W'(DEFAULT_TAPS_4),
    parameter logic [W-1:0] RESET_SEED = W'(DEFAULT_SEED_4),
    parameter int unsigned  STEPS      = 1
) (
    input logic                 clk,
    input logic                 rst,
    lfsr_rr_scheduler_if.slave  bus
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = 8;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] step_cnt;
    logic [N-1:0]     grant;
    logic             rnd_valid;
    logic [W-1:0]     rnd_data;
    logic             lockup;

    logic [W-1:0]     lfsr;
    logic [W-1:0]     load_value;
    logic [IDX_W-1:0] pick;
    logic             any_req;
    logic             lfsr_zero;
    logic             core_load;
    logic             core_step;

    // First set request at or above ptr, wrapping modulo N.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int unsigned      j;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && r[IDX_W'(j)]) begin
                sel   = IDX_W'(j);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign any_req    = |bus.req;
    assign pick       = rr_pick(bus.req, rr_ptr);
    assign lfsr_zero  = (lfsr == '0);
    // A zero state is replaced by 1 on the next advance instead of stepping.
    assign core_load  = bus.seed_load || ((state == ADVANCE) && lfsr_zero);
    assign core_step  = (state == ADVANCE) && !bus.seed_load;
    assign load_value = (bus.seed_load && (bus.seed != '0)) ? bus.seed : W'(1);

    lfsr_core #(
        .W          (W),
        .TAPS       (TAPS),
        .RESET_SEED (RESET_SEED)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .step       (core_step),
        .load       (core_load),
        .load_value (load_value),
        .value      (lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            step_cnt  <= '0;
            grant     <= '0;
            rnd_valid <= 1'b0;
            rnd_data  <= '0;
            lockup    <= 1'b0;
        end else begin
            grant     <= '0;
            rnd_valid <= 1'b0;
            lockup    <= 1'b0;
            if (bus.seed_load) begin
                state  <= IDLE;
                lockup <= (bus.seed == '0);
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.enable && any_req) begin
                            state <= GRANT;
                        end
                    end
                    GRANT: begin
                        if (any_req) begin
                            grant     <= N'(1) << pick;
                            rnd_valid <= 1'b1;
                            rnd_data  <= lfsr;
                            rr_ptr    <= IDX_W'((32'(pick) + 32'd1) % N);
                            step_cnt  <= CNT_W'(STEPS - 1);
                            state     <= ADVANCE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    ADVANCE: begin
                        if (lfsr_zero) begin
                            lockup <= 1'b1;
                        end
                        if (step_cnt == '0) begin
                            state <= (bus.enable && any_req) ? GRANT : IDLE;
                        end else begin
                            step_cnt <= step_cnt - CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.grant     = grant;
    assign bus.rnd_valid = rnd_valid;
    assign bus.rnd_data  = rnd_data;
    assign bus.lockup    = lockup;

endmodule

// File: tb/tb_lfsr_rr_scheduler.sv
// Directed and random checks of lfsr_rr_scheduler (STEPS=1 and STEPS=3 instances)
// against a cycle-level reference model of the arbitration and LFSR rules.
module tb_lfsr_rr_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_rr_scheduler_if #(.N(4), .W(4)) bus_a ();
    lfsr_rr_scheduler_if #(.N(4), .W(4)) bus_b ();

    lfsr_rr_scheduler #(.N(4), .W(4), .TAPS(4'b0011), .RESET_SEED(4'b0001), .STEPS(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    lfsr_rr_scheduler #(.N(4), .W(4), .TAPS(4'b0011), .RESET_SEED(4'b0001), .STEPS(3))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned cyc    = 0;

    // Inputs shared by both instances
    logic       t_en, t_sl;
    logic [3:0] t_sd, t_rq;

    // Reference model state, index 0 = STEPS 1, index 1 = STEPS 3
    int         m_lfsr [2];
    int         m_ptr  [2];
    bit         m_pend [2];
    int         m_wait [2];
    logic [3:0] e_grant[2];
    logic [3:0] e_data [2];
    logic       e_valid[2];
    logic       e_lock [2];

    logic [3:0]  qa[$], qb[$], ga[$];
    int unsigned ta[$], tb_t[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int lfsr_adv(input int x);
        int v;
        v = (x * 2) % 16;
        if (x >= 8) v = v ^ 3;
        return v;
    endfunction

    function automatic int pick(input int r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lfsr[i] = 1; m_ptr[i] = 0; m_pend[i] = 0; m_wait[i] = 0;
            e_grant[i] = '0; e_data[i] = '0; e_valid[i] = 1'b0; e_lock[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        int st;
        int w;
        st = (i == 0) ? 1 : 3;
        e_grant[i] = '0; e_valid[i] = 1'b0; e_lock[i] = 1'b0;
        if (t_sl) begin
            m_lfsr[i] = (t_sd == 0) ? 1 : int'(t_sd);
            e_lock[i] = (t_sd == 0);
            m_pend[i] = 0; m_wait[i] = 0;
        end else if (m_pend[i]) begin
            m_pend[i] = 0;
            if (t_rq != 0) begin
                w = pick(int'(t_rq), m_ptr[i]);
                e_grant[i] = 4'(1 << w);
                e_valid[i] = 1'b1;
                e_data[i]  = 4'(m_lfsr[i]);
                m_ptr[i]   = (w + 1) % 4;
                m_wait[i]  = st;
            end
        end else if (m_wait[i] > 0) begin
            if (m_lfsr[i] == 0) begin
                m_lfsr[i] = 1; e_lock[i] = 1'b1;
            end else begin
                m_lfsr[i] = lfsr_adv(m_lfsr[i]);
            end
            m_wait[i]--;
            if (m_wait[i] == 0 && t_en && t_rq != 0) m_pend[i] = 1;
        end else if (t_en && t_rq != 0) begin
            m_pend[i] = 1;
        end
    endtask

    task automatic set_in(input logic en, input logic sl, input logic [3:0] sd, input logic [3:0] rq);
        t_en = en; t_sl = sl; t_sd = sd; t_rq = rq;
        bus_a.enable = en; bus_a.seed_load = sl; bus_a.seed = sd; bus_a.req = rq;
        bus_b.enable = en; bus_b.seed_load = sl; bus_b.seed = sd; bus_b.req = rq;
    endtask

    task automatic clear_q();
        qa.delete(); qb.delete(); ga.delete(); ta.delete(); tb_t.delete();
    endtask

    // One clock: advance the model, then compare both instances 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check("a_grant", 32'(bus_a.grant), 32'(e_grant[0]));
        check("a_valid", 32'(bus_a.rnd_valid), 32'(e_valid[0]));
        check("a_lockup", 32'(bus_a.lockup), 32'(e_lock[0]));
        if (e_valid[0]) check("a_data", 32'(bus_a.rnd_data), 32'(e_data[0]));
        check("b_grant", 32'(bus_b.grant), 32'(e_grant[1]));
        check("b_valid", 32'(bus_b.rnd_valid), 32'(e_valid[1]));
        check("b_lockup", 32'(bus_b.lockup), 32'(e_lock[1]));
        if (e_valid[1]) check("b_data", 32'(bus_b.rnd_data), 32'(e_data[1]));
        if (bus_a.rnd_valid) begin
            qa.push_back(bus_a.rnd_data); ga.push_back(bus_a.grant); ta.push_back(cyc);
        end
        if (bus_b.rnd_valid) begin
            qb.push_back(bus_b.rnd_data); tb_t.push_back(cyc);
        end
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_a_grant", 32'(bus_a.grant), 32'd0);
        check("rst_a_valid", 32'(bus_a.rnd_valid), 32'd0);
        check("rst_a_data", 32'(bus_a.rnd_data), 32'd0);
        check("rst_a_lockup", 32'(bus_a.lockup), 32'd0);
        check("rst_b_grant", 32'(bus_b.grant), 32'd0);
        check("rst_b_valid", 32'(bus_b.rnd_valid), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
    endtask

    initial begin
        logic [3:0] sd;
        rst = 1'b1;
        set_in(1'b0, 1'b0, 4'd0, 4'd0);
        model_reset();

        // Single requester, STEPS 1 and 3: LFSR sequence and grant spacing
        do_reset();
        set_in(1'b1, 1'b0, 4'd0, 4'b0001);
        repeat (34) tick();
        check("seq_a0", 32'(qa[0]), 32'h1);
        check("seq_a1", 32'(qa[1]), 32'h2);
        check("seq_a2", 32'(qa[2]), 32'h4);
        check("seq_a3", 32'(qa[3]), 32'h8);
        check("seq_a4", 32'(qa[4]), 32'h3);
        check("seq_a5", 32'(qa[5]), 32'h6);
        check("period15", 32'(qa[15]), 32'h1);
        check("first_lat", ta[0], 32'd2);
        check("spacing_a", ta[1] - ta[0], 32'd2);
        check("seq_b0", 32'(qb[0]), 32'h1);
        check("seq_b1", 32'(qb[1]), 32'h8);
        check("seq_b2", 32'(qb[2]), 32'hC);
        check("spacing_b", tb_t[1] - tb_t[0], 32'd4);

        // All requesting: rotation
        do_reset();
        set_in(1'b1, 1'b0, 4'd0, 4'b1111);
        repeat (10) tick();
        check("rot0", 32'(ga[0]), 32'h1);
        check("rot1", 32'(ga[1]), 32'h2);
        check("rot2", 32'(ga[2]), 32'h4);
        check("rot3", 32'(ga[3]), 32'h8);
        check("rot4", 32'(ga[4]), 32'h1);

        // Sparse requests: non-requesters skipped
        do_reset();
        set_in(1'b1, 1'b0, 4'd0, 4'b1010);
        repeat (6) tick();
        check("sparse0", 32'(ga[0]), 32'h2);
        check("sparse1", 32'(ga[1]), 32'h8);
        check("sparse2", 32'(ga[2]), 32'h2);

        // Zero seed loaded mid-ADVANCE: lockup pulse, no grant, restart from 1
        do_reset();
        set_in(1'b1, 1'b0, 4'd0, 4'b0001);
        repeat (4) tick();
        set_in(1'b1, 1'b1, 4'd0, 4'b0001);
        tick();
        check("seedz_lockup", 32'(bus_a.lockup), 32'd1);
        check("seedz_nogrant", 32'(bus_a.grant), 32'd0);
        set_in(1'b1, 1'b0, 4'd0, 4'b0001);
        clear_q();
        repeat (2) tick();
        check("seedz_next", 32'(qa[0]), 32'h1);

        // enable low blocks grants; raising it gives a grant two cycles later
        do_reset();
        set_in(1'b0, 1'b0, 4'd0, 4'b1111);
        repeat (5) tick();
        check("dis_nogrant", qa.size(), 32'd0);
        set_in(1'b1, 1'b0, 4'd0, 4'b1111);
        tick();
        check("en_lat1", 32'(bus_a.grant), 32'd0);
        tick();
        check("en_lat2", 32'(bus_a.grant), 32'h1);

        // Reset during ADVANCE (grant still showing) clears at once
        do_reset();
        set_in(1'b1, 1'b0, 4'd0, 4'b0001);
        repeat (2) tick();
        check("pre_rst_grant", 32'(bus_a.grant), 32'h1);
        do_reset();
        repeat (2) tick();
        check("post_rst_data", 32'(qa[0]), 32'h1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            sd = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            set_in($urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, sd,
                   4'($urandom_range(0, 15)));
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
